// File: rtl/debounce_pkg.sv
// Shared defaults for the per-bit debounce stage that follows the slice synchronizer.
package debounce_pkg;
    localparam int DEFAULT_STABLE_CYCLES = 10;
    localparam int DEFAULT_CNT_W         = 4;
endpackage

// File: rtl/debounce_bit.sv
// One bit of debounce: stability counter, debounced level, registered edge pulses.
module debounce_bit #(
    parameter int   CNT_W         = 4,
    parameter int   STABLE_CYCLES = 10,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic d_sync,
    output logic q,
    output logic rise,
    output logic fall,
    output logic settling
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_p0;
    logic             q_p0;
    logic             rise_p0;
    logic             fall_p0;

    // stage p0: count enabled cycles of disagreement, commit on the last one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_p0  <= '0;
            q_p0    <= RESET_VAL;
            rise_p0 <= 1'b0;
            fall_p0 <= 1'b0;
        end else begin
            rise_p0 <= 1'b0;
            fall_p0 <= 1'b0;
            if (en) begin
                if (d_sync == q_p0) begin
                    cnt_p0 <= '0;
                end else if (cnt_p0 == LAST) begin
                    cnt_p0  <= '0;
                    q_p0    <= d_sync;
                    rise_p0 <= d_sync;
                    fall_p0 <= ~d_sync;
                end else begin
                    cnt_p0 <= cnt_p0 + CNT_W'(1);
                end
            end
        end
    end

    assign q        = q_p0;
    assign rise     = rise_p0;
    assign fall     = fall_p0;
    assign settling = (cnt_p0 != '0);

endmodule

// File: rtl/slice_debounce.sv
// Debounce and edge detect for every synchronizer slice; one independent debounce_bit per bit.
module slice_debounce
    import debounce_pkg::*;
#(
    parameter int   WIDTH         = 2,
    parameter int   CNT_W         = DEFAULT_CNT_W,
    parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d_sync,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] settling
);
    // The counter must be able to hold STABLE_CYCLES-1 without wrapping.
    if (STABLE_CYCLES < 1 || STABLE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_stable_cycles
        $error("slice_debounce: STABLE_CYCLES out of range for CNT_W");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        debounce_bit #(
            .CNT_W        (CNT_W),
            .STABLE_CYCLES(STABLE_CYCLES),
            .RESET_VAL    (RESET_VAL)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (en),
            .d_sync  (d_sync[i]),
            .q       (q[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .settling(settling[i])
        );
    end

endmodule

// File: tb/tb_slice_debounce.sv
// Directed table-driven bench for slice_debounce (STABLE_CYCLES=10) plus a STABLE_CYCLES=1 instance.
module tb_slice_debounce;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b1;
    logic [1:0] d_sync = 2'b11;
    logic [1:0] q, rise, fall, settling;
    logic [1:0] q1, rise1, fall1, settling1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    slice_debounce #(.WIDTH(2), .CNT_W(4), .STABLE_CYCLES(10), .RESET_VAL(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .d_sync(d_sync),
        .q(q), .rise(rise), .fall(fall), .settling(settling)
    );

    slice_debounce #(.WIDTH(2), .CNT_W(4), .STABLE_CYCLES(1), .RESET_VAL(1'b0)) dut1 (
        .clk(clk), .reset_n(reset_n), .en(en), .d_sync(d_sync),
        .q(q1), .rise(rise1), .fall(fall1), .settling(settling1)
    );

    typedef struct {
        int         n;
        logic       en;
        logic       rst_n;
        logic [1:0] d;
        logic [1:0] q;
        logic [1:0] r;
        logic [1:0] f;
        logic [1:0] s;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [1:0] eq, input logic [1:0] er,
                        input logic [1:0] ef, input logic [1:0] es);
        chk({tag, ".q"}, q, eq);
        chk({tag, ".rise"}, rise, er);
        chk({tag, ".fall"}, fall, ef);
        chk({tag, ".settling"}, settling, es);
    endtask

    task automatic step(input logic e, input logic r, input logic [1:0] dd);
        @(negedge clk);
        en = e;
        reset_n = r;
        d_sync = dd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // n, en, rst_n, d, q, rise, fall, settling
        tbl.push_back('{3, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{9, 1'b1, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11});
        tbl.push_back('{1, 1'b1, 1'b1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00});
        tbl.push_back('{1, 1'b1, 1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{9, 1'b1, 1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11});
        tbl.push_back('{1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00});
        tbl.push_back('{1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
        // glitch of 9 cycles on bit 0, returning on the final counting edge
        tbl.push_back('{9, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01});
        tbl.push_back('{1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
        // clean rise then fall on bit 1
        tbl.push_back('{9, 1'b1, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10});
        tbl.push_back('{1, 1'b1, 1'b1, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00});
        tbl.push_back('{10, 1'b1, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{9, 1'b1, 1'b1, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10});
        tbl.push_back('{1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00});
        tbl.push_back('{1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
        // simultaneous opposite changes on both bits
        tbl.push_back('{9, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01});
        tbl.push_back('{1, 1'b1, 1'b1, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00});
        tbl.push_back('{9, 1'b1, 1'b1, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11});
        tbl.push_back('{1, 1'b1, 1'b1, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00});
        tbl.push_back('{9, 1'b1, 1'b1, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10});
        tbl.push_back('{1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00});

        #1;
        chk4("reset_hold", 2'b00, 2'b00, 2'b00, 2'b00);

        for (int v = 0; v < tbl.size(); v++) begin
            for (int c = 0; c < tbl[v].n; c++) begin
                step(tbl[v].en, tbl[v].rst_n, tbl[v].d);
                chk4($sformatf("tbl%0d_c%0d", v, c), tbl[v].q, tbl[v].r, tbl[v].f, tbl[v].s);
            end
        end

        // enable gating: 10 enabled cycles interleaved with disabled ones
        for (int k = 0; k < 9; k++) begin
            step(1'b1, 1'b1, 2'b01);
            chk4($sformatf("en_on%0d", k), 2'b00, 2'b00, 2'b00, 2'b01);
            step(1'b0, 1'b1, 2'b01);
            chk4($sformatf("en_off%0d", k), 2'b00, 2'b00, 2'b00, 2'b01);
        end
        step(1'b1, 1'b1, 2'b01);
        chk4("en_commit", 2'b01, 2'b01, 2'b00, 2'b00);
        step(1'b0, 1'b1, 2'b01);
        chk4("en_pulse_drop", 2'b01, 2'b00, 2'b00, 2'b00);

        // reset mid-count on bit 1, bit 0 returns to reset level
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b1, 2'b11);
            chk4($sformatf("mid_cnt%0d", k), 2'b01, 2'b00, 2'b00, 2'b10);
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk4("mid_async_rst", 2'b00, 2'b00, 2'b00, 2'b00);
        step(1'b1, 1'b0, 2'b11);
        chk4("mid_rst_hold", 2'b00, 2'b00, 2'b00, 2'b00);
        for (int k = 0; k < 9; k++) begin
            step(1'b1, 1'b1, 2'b11);
            chk4($sformatf("post_rst%0d", k), 2'b00, 2'b00, 2'b00, 2'b11);
        end
        step(1'b1, 1'b1, 2'b11);
        chk4("post_rst_commit", 2'b11, 2'b11, 2'b00, 2'b00);

        // reset while a pulse is visible clears it at once
        #2;
        reset_n = 1'b0;
        #1;
        chk4("pulse_rst_clear", 2'b00, 2'b00, 2'b00, 2'b00);
        step(1'b1, 1'b1, 2'b00);
        chk4("pulse_rst_release", 2'b00, 2'b00, 2'b00, 2'b00);

        // STABLE_CYCLES=1 instance: q follows d_sync one cycle later
        step(1'b1, 1'b1, 2'b01);
        chk("s1.q_a", q1, 2'b01); chk("s1.rise_a", rise1, 2'b01); chk("s1.fall_a", fall1, 2'b00);
        step(1'b1, 1'b1, 2'b11);
        chk("s1.q_b", q1, 2'b11); chk("s1.rise_b", rise1, 2'b10); chk("s1.fall_b", fall1, 2'b00);
        step(1'b1, 1'b1, 2'b10);
        chk("s1.q_c", q1, 2'b10); chk("s1.rise_c", rise1, 2'b00); chk("s1.fall_c", fall1, 2'b01);
        step(1'b1, 1'b1, 2'b01);
        chk("s1.q_d", q1, 2'b01); chk("s1.rise_d", rise1, 2'b01); chk("s1.fall_d", fall1, 2'b10);
        chk("s1.settling_d", settling1, 2'b00);
        step(1'b1, 1'b1, 2'b01);
        chk("s1.q_e", q1, 2'b01); chk("s1.rise_e", rise1, 2'b00); chk("s1.fall_e", fall1, 2'b00);
        step(1'b0, 1'b1, 2'b10);
        chk("s1.q_hold", q1, 2'b01); chk("s1.rise_hold", rise1, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
